dcm_lock_sequencer: RTL and testbench

Reset/lock sequencer for the two cascaded clock managers: the main 214 MHz DCM and the phase-shift DCM fed from its CLKFX. Runs on the free-running board input clock, not on any DCM output. It pulses each DCM reset in order, waits for lock with timeout and retry, and holds the system reset until both DCMs are locked and settled. On any loss of lock or stopped-clock status it restarts the whole sequence.

---
 rtl/dcm_lock_sequencer_pkg.sv | 27 ++
 rtl/dcm_lock_sequencer_sync2.sv | 25 ++
 rtl/dcm_lock_sequencer.sv | 136 +++++++++++++
 tb/tb_dcm_lock_sequencer.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/dcm_lock_sequencer_pkg.sv
// Shared types and constants for the DCM reset/lock sequencer.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package dcm_lock_sequencer_pkg;

  // Sequencer states, in bring-up order; FAULT is terminal until NReset.
  typedef enum logic [2:0] {
    RST1   = 3'd0,
    WAIT1  = 3'd1,
    RST2   = 3'd2,
    WAIT2  = 3'd3,
    SETTLE = 3'd4,
    RUN    = 3'd5,
    FAULT  = 3'd6
  } state_t;

  // DCM STATUS bit positions that indicate a stopped clock.
  localparam int ST_CLKIN_STOP = 1;
  localparam int ST_CLKFX_STOP = 2;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/dcm_lock_sequencer_sync2.sv
// Two-flop synchronizer for one asynchronous level into the Clock domain.
// Latency: 2 cycles from input change to q.
// Backpressure: none; a pure level sampler.
// Ports: clk - sampling clock; rst_n - async active-low clear;
//        d - asynchronous input; q - synchronized output.
module dcm_lock_sequencer_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/dcm_lock_sequencer.sv
// Sequences resets for the cascaded main and phase-shift DCMs, holds SysRst until both lock and settle.
// Latency: input edge -> outputs in 3 cycles (2 sync + 1 state register); outputs are registered.
// Backpressure: none; lock loss or stopped clock always restarts the sequence from RST1.
// Ports: Clock/NReset - free-running reference clock and async active-low reset;
//        Locked1_I, Status1_I, Locked2_I - asynchronous DCM status inputs;
//        Dcm1Rst_O, Dcm2Rst_O, SysRst_O - active-high resets; Ready_O (RUN), Fault_O (FAULT);
//        Retries_O - consecutive lock-timeout count, saturating at 15.
module dcm_lock_sequencer
  import dcm_lock_sequencer_pkg::*;
#(
  parameter int RST_CYCLES    = 8,
  parameter int LOCK_TIMEOUT  = 1048576,
  parameter int SETTLE_CYCLES = 1024,
  parameter int MAX_RETRIES   = 7
) (
  input  logic       Clock,
  input  logic       NReset,
  input  logic       Locked1_I,
  input  logic [7:0] Status1_I,
  input  logic       Locked2_I,
  output logic       Dcm1Rst_O,
  output logic       Dcm2Rst_O,
  output logic       SysRst_O,
  output logic       Ready_O,
  output logic       Fault_O,
  output logic [3:0] Retries_O
);

  // Every load is a parameter minus one, so clog2 of the largest parameter is enough bits.
  localparam int CNT_MAX = max3(RST_CYCLES, LOCK_TIMEOUT, SETTLE_CYCLES);
  localparam int CNT_W   = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] RST_LOAD    = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] WAIT_LOAD   = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [3:0]       MAX_R       = 4'((MAX_RETRIES > 15) ? 15 : MAX_RETRIES);

  logic l1, l2, s1, s2, bad;
  logic unused_status;

  dcm_lock_sequencer_sync2 u_sync_l1 (.clk(Clock), .rst_n(NReset), .d(Locked1_I),                .q(l1));
  dcm_lock_sequencer_sync2 u_sync_l2 (.clk(Clock), .rst_n(NReset), .d(Locked2_I),                .q(l2));
  dcm_lock_sequencer_sync2 u_sync_s1 (.clk(Clock), .rst_n(NReset), .d(Status1_I[ST_CLKIN_STOP]), .q(s1));
  dcm_lock_sequencer_sync2 u_sync_s2 (.clk(Clock), .rst_n(NReset), .d(Status1_I[ST_CLKFX_STOP]), .q(s2));

  // Remaining STATUS bits carry no information the sequencer acts on.
  assign unused_status = ^{Status1_I[7:3], Status1_I[0]};

  assign bad = s1 | s2 | ~l1;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_load;
  logic [3:0]       retries_nxt;
  logic             expire, timeout;

  assign expire = (cnt == '0);

  always_comb begin
    state_nxt   = state;
    retries_nxt = Retries_O;
    timeout     = 1'b0;
    cnt_load    = RST_LOAD;

    // Within each state: bad > timeout > normal progress.
    unique case (state)
      RST1:   if (expire) state_nxt = WAIT1;
      WAIT1: begin
        if (expire)  timeout   = 1'b1;
        else if (l1) state_nxt = RST2;
      end
      RST2: begin
        if (bad)         state_nxt = RST1;
        else if (expire) state_nxt = WAIT2;
      end
      WAIT2: begin
        if (bad)         state_nxt = RST1;
        else if (expire) timeout   = 1'b1;
        else if (l2)     state_nxt = SETTLE;
      end
      SETTLE: begin
        if (bad || !l2) begin
          state_nxt = RST1;
        end else if (expire) begin
          state_nxt   = RUN;
          retries_nxt = 4'd0;
        end
      end
      RUN:    if (bad || !l2) state_nxt = RST1;
      FAULT:  state_nxt = FAULT;
      default: state_nxt = RST1;
    endcase

    // A timeout with the retry budget already spent is terminal.
    if (timeout) begin
      if (Retries_O >= MAX_R) begin
        state_nxt = FAULT;
      end else begin
        state_nxt   = RST1;
        retries_nxt = (Retries_O == 4'd15) ? 4'd15 : Retries_O + 4'd1;
      end
    end

    unique case (state_nxt)
      RST1, RST2:   cnt_load = RST_LOAD;
      WAIT1, WAIT2: cnt_load = WAIT_LOAD;
      SETTLE:       cnt_load = SETTLE_LOAD;
      default:      cnt_load = '0;
    endcase
  end

  always_ff @(posedge Clock or negedge NReset) begin
    if (!NReset) begin
      state     <= RST1;
      cnt       <= RST_LOAD;
      Retries_O <= 4'd0;
      Dcm1Rst_O <= 1'b1;
      Dcm2Rst_O <= 1'b1;
      SysRst_O  <= 1'b1;
      Ready_O   <= 1'b0;
      Fault_O   <= 1'b0;
    end else begin
      state     <= state_nxt;
      Retries_O <= retries_nxt;
      // Reload on every state change so each state sees a fresh interval.
      if (state_nxt != state) cnt <= cnt_load;
      else if (!expire)       cnt <= cnt - 1'b1;
      // Outputs are decoded from the next state so they change with the state register.
      Dcm1Rst_O <= (state_nxt == RST1) || (state_nxt == FAULT);
      Dcm2Rst_O <= (state_nxt == RST1) || (state_nxt == RST2) || (state_nxt == FAULT);
      SysRst_O  <= (state_nxt != RUN);
      Ready_O   <= (state_nxt == RUN);
      Fault_O   <= (state_nxt == FAULT);
    end
  end

endmodule

// File: tb/tb_dcm_lock_sequencer.sv
`timescale 1ns/1ps
module tb_dcm_lock_sequencer;

  logic       Clock;
  logic       NReset;
  logic       Locked1_I;
  logic [7:0] Status1_I;
  logic       Locked2_I;
  logic       Dcm1Rst_O, Dcm2Rst_O, SysRst_O, Ready_O, Fault_O;
  logic [3:0] Retries_O;

  dcm_lock_sequencer #(
    .RST_CYCLES(4), .LOCK_TIMEOUT(100), .SETTLE_CYCLES(16), .MAX_RETRIES(3)
  ) dut (
    .Clock(Clock), .NReset(NReset), .Locked1_I(Locked1_I), .Status1_I(Status1_I),
    .Locked2_I(Locked2_I), .Dcm1Rst_O(Dcm1Rst_O), .Dcm2Rst_O(Dcm2Rst_O),
    .SysRst_O(SysRst_O), .Ready_O(Ready_O), .Fault_O(Fault_O), .Retries_O(Retries_O)
  );

  // 10 ns period: 100 cycles = 1 us.
  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Output vector layout: {Dcm1Rst, Dcm2Rst, SysRst, Ready, Fault, Retries[3:0]}
  localparam logic [8:0] O_RST1  = 9'b1_1_1_0_0_0000;
  localparam logic [8:0] O_WAIT  = 9'b0_0_1_0_0_0000;
  localparam logic [8:0] O_RST2  = 9'b0_1_1_0_0_0000;
  localparam logic [8:0] O_RUN   = 9'b0_0_0_1_0_0000;
  localparam logic [8:0] O_FAULT = 9'b1_1_1_0_1_0000;
  localparam logic [8:0] M_ALL   = 9'h1FF;
  localparam logic [8:0] M_NORET = 9'h1F0;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    int         cyc;
    logic       l1;
    logic       l2;
    logic [7:0] st;
    logic [8:0] exp;
  } vec_t;

  vec_t vec[12];

  task automatic tick();
    @(negedge Clock);
    cyc++;
  endtask

  task automatic adv_to(input int n);
    while (cyc < n) tick();
  endtask

  task automatic chk(input string name, input logic [8:0] exp, input logic [8:0] mask);
    logic [8:0] act;
    act = {Dcm1Rst_O, Dcm2Rst_O, SysRst_O, Ready_O, Fault_O, Retries_O};
    checks++;
    if ((act & mask) !== (exp & mask)) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%b want=%b mask=%b", name, cyc, act, exp, mask);
    end
  endtask

  // Release NReset on a falling edge; cycle count restarts at 0.
  task automatic do_reset(input logic l1, input logic l2, input logic [7:0] st);
    @(negedge Clock);
    NReset    = 1'b0;
    Locked1_I = l1;
    Locked2_I = l2;
    Status1_I = st;
    repeat (3) @(negedge Clock);
    NReset = 1'b1;
    cyc    = 0;
  endtask

  task automatic wait_ready(input string name, input int bound);
    int n;
    n = 0;
    while (!Ready_O && n < bound) begin
      tick();
      n++;
    end
    checks++;
    if (!Ready_O) begin
      failures++;
      $display("FAIL %s Ready_O=%b after %0d cycles, want 1", name, Ready_O, n);
    end
  endtask

  initial begin
    NReset    = 1'b0;
    Locked1_I = 1'b0;
    Locked2_I = 1'b0;
    Status1_I = 8'h00;

    // Clean bring-up: L1 at cycle 20, L2 at cycle 50.
    vec[0]  = '{0,  1'b0, 1'b0, 8'h00, O_RST1};
    vec[1]  = '{3,  1'b0, 1'b0, 8'h00, O_RST1};
    vec[2]  = '{4,  1'b0, 1'b0, 8'h00, O_WAIT};
    vec[3]  = '{20, 1'b1, 1'b0, 8'h00, O_WAIT};
    vec[4]  = '{22, 1'b1, 1'b0, 8'h00, O_WAIT};
    vec[5]  = '{23, 1'b1, 1'b0, 8'h00, O_RST2};
    vec[6]  = '{26, 1'b1, 1'b0, 8'h00, O_RST2};
    vec[7]  = '{27, 1'b1, 1'b0, 8'h00, O_WAIT};
    vec[8]  = '{50, 1'b1, 1'b1, 8'h00, O_WAIT};
    vec[9]  = '{53, 1'b1, 1'b1, 8'h00, O_WAIT};
    vec[10] = '{68, 1'b1, 1'b1, 8'h00, O_WAIT};
    vec[11] = '{69, 1'b1, 1'b1, 8'h00, O_RUN};

    do_reset(1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 12; i++) begin
      adv_to(vec[i].cyc);
      chk($sformatf("bringup_vec%0d", i), vec[i].exp, M_ALL);
      Locked1_I = vec[i].l1;
      Locked2_I = vec[i].l2;
      Status1_I = vec[i].st;
    end

    // Loss of Locked1 in RUN for 1 us.
    adv_to(80);
    Locked1_I = 1'b0;
    adv_to(82); chk("l1loss_pre",  O_RUN,  M_ALL);
    adv_to(83); chk("l1loss_edge", O_RST1, M_ALL);
    adv_to(180);
    Locked1_I = 1'b1;
    adv_to(203); chk("l1loss_settle", O_WAIT, M_ALL);
    adv_to(204); chk("l1loss_rerun",  O_RUN,  M_ALL);

    // CLKFX stopped in RUN with Locked1 still high.
    adv_to(220);
    Status1_I = 8'h04;
    adv_to(222); chk("clkfx_pre",  O_RUN,  M_ALL);
    adv_to(223); chk("clkfx_edge", O_RST1, M_ALL);
    adv_to(230);
    Status1_I = 8'h00;
    wait_ready("clkfx_rerun", 300);
    chk("clkfx_retries", O_RUN, M_ALL);

    // Locked2 glitch mid-SETTLE (SETTLE spans cycles 10..25 here).
    do_reset(1'b1, 1'b1, 8'h00);
    adv_to(10); chk("glitch_settle", O_WAIT, M_ALL);
    adv_to(15);
    Locked2_I = 1'b0;
    adv_to(17);
    Locked2_I = 1'b1;
    chk("glitch_pre", O_WAIT, M_ALL);
    adv_to(18); chk("glitch_rst1", O_RST1, M_ALL);
    while (cyc < 43) begin
      tick();
      checks++;
      if (Ready_O !== 1'b0) begin
        failures++;
        $display("FAIL glitch_noready cyc=%0d Ready_O=%b want 0", cyc, Ready_O);
      end
    end
    adv_to(44); chk("glitch_rerun", O_RUN, M_ALL);

    // Locked1 held low: timeouts every 104 cycles, 4th one faults.
    do_reset(1'b0, 1'b0, 8'h00);
    adv_to(103); chk("to_wait1",  O_WAIT,          M_ALL);
    adv_to(104); chk("to_retry1", O_RST1 | 9'd1,   M_ALL);
    adv_to(107); chk("to_pulse1", O_RST1 | 9'd1,   M_ALL);
    adv_to(108); chk("to_wait1b", O_WAIT | 9'd1,   M_ALL);
    adv_to(207); chk("to_pre2",   O_WAIT | 9'd1,   M_ALL);
    adv_to(208); chk("to_retry2", O_RST1 | 9'd2,   M_ALL);
    adv_to(312); chk("to_retry3", O_RST1 | 9'd3,   M_ALL);
    adv_to(415); chk("to_prefault", O_WAIT | 9'd3, M_ALL);
    adv_to(416); chk("to_fault",  O_FAULT,         M_NORET);
    adv_to(420);
    Locked1_I = 1'b1;
    Locked2_I = 1'b1;
    adv_to(600); chk("fault_hold", O_FAULT, M_NORET);
    NReset = 1'b0;
    #1;
    chk("fault_nreset", O_RST1, M_ALL);

    // Asynchronous reset in WAIT2 after one WAIT2 timeout.
    do_reset(1'b1, 1'b0, 8'h00);
    adv_to(108); chk("w2_pre",   O_WAIT,        M_ALL);
    adv_to(109); chk("w2_retry", O_RST1 | 9'd1, M_ALL);
    adv_to(120); chk("w2_wait",  O_WAIT | 9'd1, M_ALL);
    #1;
    NReset = 1'b0;
    #1;
    chk("w2_async_rst", O_RST1, M_ALL);
    @(negedge Clock);
    NReset = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard stop in case a wait above never completes.
  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
